// File: rtl/cdr_pkg.sv
// Shared types and default constants for the oversampled bang-bang CDR.
package cdr_pkg;

  localparam int unsigned CDR_OSR      = 8;
  localparam int unsigned CDR_ACC_W    = 6;
  localparam int unsigned CDR_THRESH   = 8;
  localparam int unsigned CDR_LOCK_CNT = 32;

  typedef enum logic [1:0] {
    VOTE_NONE  = 2'd0,
    VOTE_EARLY = 2'd1,
    VOTE_LATE  = 2'd2
  } vote_t;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_ADV  = 2'd1,
    STEP_RET  = 2'd2
  } step_t;

  // Reduced trip magnitude used during acquisition, never below 1.
  function automatic int unsigned fast_trip(input int unsigned thresh);
    return ((thresh / 2) < 1) ? 1 : (thresh / 2);
  endfunction

endpackage

// File: rtl/cdr_vote_acc.sv
// Signed vote integrator with symmetric threshold trip.
// A trip clears the integrator and reports the phase step direction.
module cdr_vote_acc
  import cdr_pkg::*;
#(
  parameter int unsigned ACC_W = CDR_ACC_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  vote_t            vote,
  input  logic [ACC_W-1:0] trip,
  output step_t            step_c,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0] acc_next;

  // Next integrator value and trip decision.
  always_comb begin
    acc_next = acc;
    step_c   = STEP_NONE;
    case (vote)
      VOTE_LATE:  acc_next = acc + ACC_W'(1);
      VOTE_EARLY: acc_next = acc - ACC_W'(1);
      default:    acc_next = acc;
    endcase
    if (!clr) begin
      if ($signed(acc_next) >= $signed(trip)) begin
        step_c = STEP_RET;
      end else if ($signed(acc_next) <= -$signed(trip)) begin
        step_c = STEP_ADV;
      end
    end
  end

  // Integrator register; cleared by disable or by a trip.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc <= '0;
    end else if (clr || (step_c != STEP_NONE)) begin
      acc <= '0;
    end else begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/cdr_bb_pd_os.sv
// Oversampled bang-bang phase detector with vote integrator, bit sampler
// and lock detector.
// Build option: CDR_PD_FASTACQ_EN halves the trip magnitude while unlocked.
module cdr_bb_pd_os
  import cdr_pkg::*;
#(
  parameter int unsigned OSR      = CDR_OSR,
  parameter int unsigned ACC_W    = CDR_ACC_W,
  parameter int unsigned THRESH   = CDR_THRESH,
  parameter int unsigned LOCK_CNT = CDR_LOCK_CNT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             data_in,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             early,
  output logic             late,
  output logic             step_adv,
  output logic             step_ret,
  output logic             locked,
  output logic [ACC_W-1:0] acc_out
);

  localparam int unsigned PH_W = $clog2(OSR);
  localparam int unsigned LC_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned HALF = OSR / 2;

  localparam logic [PH_W-1:0]  PH_SAMP   = PH_W'(HALF - 1);
  localparam logic [PH_W-1:0]  PH_PRE    = PH_W'(HALF - 2);
  localparam logic [PH_W-1:0]  PH_HALF   = PH_W'(HALF);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0]  PH_WRAP2  = PH_W'(OSR - 2);
  localparam logic [LC_W-1:0]  LC_MAX    = LC_W'(LOCK_CNT);
  localparam logic [ACC_W-1:0] TRIP_FULL = ACC_W'(THRESH);
`ifdef CDR_PD_FASTACQ_EN
  localparam logic [ACC_W-1:0] TRIP_FAST = ACC_W'(fast_trip(THRESH));
`endif

  logic             d_q;
  logic             d_prev;
  logic [PH_W-1:0]  ph;
  logic [LC_W-1:0]  lock_cnt;
  logic             step_seen;

  logic             data_edge_c;
  vote_t            vote_c;
  step_t            step_c;
  logic [ACC_W-1:0] trip_c;
  logic [PH_W-1:0]  ph_next_c;
  logic             strobe_c;
  logic [LC_W-1:0]  cnt_next_c;
  logic             seen_next_c;

  // Transition detect and early/late classification against the phase counter.
  always_comb begin
    data_edge_c = d_q ^ d_prev;
    vote_c      = VOTE_NONE;
    if (data_edge_c && (ph != '0)) begin
      vote_c = (ph < PH_HALF) ? VOTE_LATE : VOTE_EARLY;
    end
  end

  // Trip magnitude; optionally relaxed until lock is reached.
  always_comb begin
`ifdef CDR_PD_FASTACQ_EN
    trip_c = locked ? TRIP_FULL : TRIP_FAST;
`else
    trip_c = TRIP_FULL;
`endif
  end

  cdr_vote_acc #(
    .ACC_W (ACC_W)
  ) u_vote_acc (
    .clk    (clk),
    .resetn (resetn),
    .clr    (~en),
    .vote   (vote_c),
    .trip   (trip_c),
    .step_c (step_c),
    .acc    (acc_out)
  );

  // Phase advance, sample strobe and lock counter next-state.
  always_comb begin
    ph_next_c   = ph;
    strobe_c    = 1'b0;
    cnt_next_c  = lock_cnt;
    seen_next_c = step_seen;

    case (step_c)
      STEP_RET: ph_next_c = ph;
      STEP_ADV: ph_next_c = (ph >= PH_WRAP2) ? (ph - PH_WRAP2) : (ph + PH_W'(2));
      default:  ph_next_c = (ph == PH_LAST) ? '0 : (ph + PH_W'(1));
    endcase

    // The counter passing the sample slot fires exactly once per revolution.
    strobe_c = ((ph == PH_SAMP) && (step_c != STEP_RET)) ||
               ((ph == PH_PRE)  && (step_c == STEP_ADV));

    if (step_c != STEP_NONE) begin
      cnt_next_c  = '0;
      seen_next_c = 1'b1;
    end else if (strobe_c) begin
      if (step_seen) begin
        seen_next_c = 1'b0;
      end else if (lock_cnt != LC_MAX) begin
        cnt_next_c = lock_cnt + LC_W'(1);
      end
    end
  end

  // Input pipe, phase/lock state and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      d_q       <= 1'b0;
      d_prev    <= 1'b0;
      ph        <= '0;
      lock_cnt  <= '0;
      step_seen <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      early     <= 1'b0;
      late      <= 1'b0;
      step_adv  <= 1'b0;
      step_ret  <= 1'b0;
      locked    <= 1'b0;
    end else begin
      d_q    <= data_in;
      d_prev <= d_q;
      if (!en) begin
        ph        <= '0;
        lock_cnt  <= '0;
        step_seen <= 1'b0;
        bit_valid <= 1'b0;
        early     <= 1'b0;
        late      <= 1'b0;
        step_adv  <= 1'b0;
        step_ret  <= 1'b0;
        locked    <= 1'b0;
      end else begin
        ph        <= ph_next_c;
        lock_cnt  <= cnt_next_c;
        step_seen <= seen_next_c;
        bit_valid <= strobe_c;
        if (strobe_c) begin
          bit_out <= d_q;
        end
        early    <= (vote_c == VOTE_EARLY);
        late     <= (vote_c == VOTE_LATE);
        step_adv <= (step_c == STEP_ADV);
        step_ret <= (step_c == STEP_RET);
        locked   <= (cnt_next_c == LC_MAX);
      end
    end
  end

endmodule

// File: tb/tb_cdr_bb_pd_os.sv
// Self-checking bench for cdr_bb_pd_os against a cycle-level behavioural model.
module tb_cdr_bb_pd_os;

  localparam int OSR      = 8;
  localparam int ACC_W    = 6;
  localparam int THRESH   = 8;
  localparam int LOCK_CNT = 32;
`ifdef CDR_PD_FASTACQ_EN
  localparam int TRIP_UNL = ((THRESH / 2) < 1) ? 1 : (THRESH / 2);
`else
  localparam int TRIP_UNL = THRESH;
`endif
  localparam int ACC_TGT = (TRIP_UNL > 5) ? 5 : (TRIP_UNL - 1);

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             en = 1'b0;
  logic             data_in = 1'b0;
  logic             bit_out, bit_valid, early, late, step_adv, step_ret, locked;
  logic [ACC_W-1:0] acc_out;

  cdr_bb_pd_os #(
    .OSR(OSR), .ACC_W(ACC_W), .THRESH(THRESH), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk(clk), .resetn(resetn), .en(en), .data_in(data_in),
    .bit_out(bit_out), .bit_valid(bit_valid), .early(early), .late(late),
    .step_adv(step_adv), .step_ret(step_ret), .locked(locked), .acc_out(acc_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state.
  int m_dq, m_dp, m_ph, m_acc, m_cnt, m_dirty;
  int m_bit, m_bv, m_e, m_l, m_adv, m_ret, m_lock;

  // Bookkeeping for scenario checks.
  int cyc = 0, last_bv = -1, n_strobe = 0, vote_run = 0;
  int lock_rise = -1, prev_lock = 0, since_tog = 0;
  logic cur_d = 1'b0;
  int step_votes[$];
  int step_lock[$];
  int step_isret[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_dq = 0; m_dp = 0; m_ph = 0; m_acc = 0; m_cnt = 0; m_dirty = 0;
    m_bit = 0; m_bv = 0; m_e = 0; m_l = 0; m_adv = 0; m_ret = 0; m_lock = 0;
    last_bv = -1; n_strobe = 0; vote_run = 0; prev_lock = 0;
  endtask

  // One clock of the reference behaviour, from the pre-edge state.
  task automatic model_clock(input bit en_i, input bit din);
    int v, trip, nxt, span;
    bit ret, adv, strobe;
    v = 0;
    if ((m_dq != m_dp) && (m_ph != 0)) v = (m_ph < OSR / 2) ? 1 : -1;
    if (!en_i) begin
      m_ph = 0; m_acc = 0; m_cnt = 0; m_dirty = 0;
      m_bv = 0; m_e = 0; m_l = 0; m_adv = 0; m_ret = 0; m_lock = 0;
    end else begin
      trip = (m_lock != 0) ? THRESH : TRIP_UNL;
      nxt  = m_acc + v;
      ret  = (nxt >= trip);
      adv  = (nxt <= -trip);
      span = ret ? 0 : (adv ? 2 : 1);
      strobe = 1'b0;
      for (int i = 0; i < span; i++)
        if (((m_ph + i) % OSR) == (OSR / 2 - 1)) strobe = 1'b1;
      m_e = (v < 0); m_l = (v > 0); m_adv = adv; m_ret = ret; m_bv = strobe;
      if (strobe) m_bit = m_dq;
      m_acc = (ret || adv) ? 0 : nxt;
      m_ph  = (m_ph + span) % OSR;
      if (ret || adv) begin
        m_cnt = 0; m_dirty = 1;
      end else if (strobe) begin
        if (m_dirty != 0) m_dirty = 0;
        else if (m_cnt < LOCK_CNT) m_cnt++;
      end
      m_lock = (m_cnt == LOCK_CNT);
    end
    m_dp = m_dq;
    m_dq = din;
  endtask

  task automatic compare_all();
    logic [ACC_W-1:0] exp_acc;
    exp_acc = m_acc[ACC_W-1:0];
    check("outs", 32'({bit_out, bit_valid, early, late, step_adv, step_ret, locked}),
          32'({m_bit[0], m_bv[0], m_e[0], m_l[0], m_adv[0], m_ret[0], m_lock[0]}));
    check("acc", 32'(acc_out), 32'(exp_acc));
  endtask

  // Drive one cycle from a falling edge, check after the rising edge.
  task automatic cycle(input bit en_i, input bit din);
    int gap;
    en = en_i;
    data_in = din;
    @(posedge clk);
    model_clock(en_i, din);
    #1;
    cyc++;
    compare_all();
    if (!en_i) begin
      last_bv = -1; n_strobe = 0;
    end else begin
      if (bit_valid) begin
        if (last_bv >= 0) begin
          gap = cyc - last_bv;
          check("strobe_gap", 32'(int'(gap >= OSR - 1 && gap <= OSR + 1)), 32'd1);
        end
        last_bv = cyc;
        n_strobe++;
      end
      vote_run += int'(early) + int'(late);
      if (step_adv || step_ret) begin
        step_votes.push_back(vote_run);
        step_lock.push_back(int'(locked));
        step_isret.push_back(int'(step_ret));
        check("acc_at_step", 32'(acc_out), 32'd0);
        vote_run = 0;
      end
    end
    if (locked && (prev_lock == 0) && (lock_rise < 0)) lock_rise = n_strobe;
    prev_lock = int'(locked);
    @(negedge clk);
  endtask

  // Toggle data once per UI so the edge lands at phase 'target', or randomly.
  task automatic run_mode(input int ncyc, input int target, input bit rnd);
    bit tog;
    for (int i = 0; i < ncyc; i++) begin
      if (rnd) tog = ($urandom_range(0, 5) == 0);
      else tog = (m_ph == (target + OSR - 1) % OSR) && (since_tog >= OSR - 2);
      if (tog) begin
        cur_d = ~cur_d; since_tog = 0;
      end else begin
        since_tog++;
      end
      cycle(1'b1, cur_d);
    end
  endtask

  task automatic clear_steps();
    step_votes.delete(); step_lock.delete(); step_isret.delete();
    vote_run = 0;
  endtask

  task automatic first_strobe_after_release(input string tag);
    int first;
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b1, cur_d);
      if (bit_valid && first < 0) first = k;
    end
    check(tag, 32'(first), 32'd4);
  endtask

  initial begin
    bit reached;
    model_reset();
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    resetn = 1'b1;
    first_strobe_after_release("first_strobe");

    // Aligned alternating data: no votes, lock after the LOCK_CNT-th strobe
    run_mode(45 * OSR, 0, 1'b0);
    check("lock_strobe", 32'(lock_rise), 32'(LOCK_CNT));
    check("locked_aligned", 32'(locked), 32'd1);
    check("no_steps_aligned", 32'(step_votes.size()), 32'd0);

    // Late edges at ph 2: first trip uses the locked threshold, later ones the unlocked one
    clear_steps();
    run_mode(40 * OSR, 2, 1'b0);
    check("late_nsteps", 32'(int'(step_votes.size() >= 2)), 32'd1);
    if (step_votes.size() >= 2) begin
      check("late_votes0", 32'(step_votes[0]), 32'(THRESH));
      check("late_lock_drop", 32'(step_lock[0]), 32'd0);
      check("late_is_ret", 32'(step_isret[0]), 32'd1);
      check("late_votes1", 32'(step_votes[1]), 32'(TRIP_UNL));
    end

    // Early edges at ph 6 from a cleared state
    cycle(1'b0, cur_d);
    clear_steps();
    run_mode(30 * OSR, 6, 1'b0);
    check("early_nsteps", 32'(int'(step_votes.size() >= 1)), 32'd1);
    if (step_votes.size() >= 1) begin
      check("early_votes0", 32'(step_votes[0]), 32'(TRIP_UNL));
      check("early_is_adv", 32'(step_isret[0]), 32'd0);
    end

    // Retard trips landing on the sample slot delay the strobe without doubling it
    cycle(1'b0, cur_d);
    clear_steps();
    run_mode(30 * OSR, 3, 1'b0);
    check("slot_nsteps", 32'(int'(step_votes.size() >= 1)), 32'd1);

    // Integrate to a partial value, then disable
    cycle(1'b0, cur_d);
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      run_mode(1, 2, 1'b0);
      if (m_acc == ACC_TGT) reached = 1'b1;
    end
    check("acc_reached", 32'(reached), 32'd1);
    check("acc_partial", 32'(acc_out), 32'(ACC_TGT));
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, cur_d);
      check("en_off", 32'({acc_out, early, late, step_adv, step_ret, bit_valid, locked}), 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, cur_d);
      check("reen_vote", 32'({early, late}), 32'd0);
    end

    // Randomised traffic with occasional disables
    for (int blk = 0; blk < 8; blk++) begin
      run_mode(400, -1, 1'b1);
      repeat ($urandom_range(1, 3)) cycle(1'b0, 1'($urandom_range(0, 1)));
      cur_d = data_in;
    end

    // Asynchronous reset mid-stream
    run_mode(100, -1, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst", 32'({bit_out, bit_valid, early, late, step_adv, step_ret, locked, acc_out}), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    resetn = 1'b1;
    cur_d = 1'b0;
    first_strobe_after_release("first_strobe_rst");
    run_mode(800, -1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
